// File: rtl/itlb_ptw.sv
// Sv32 page-table walker serving ITLB misses over a single-outstanding PTE read port.
// Define ITLB_PTW_PDE_CACHE_EN to add a one-entry cache of the last level-1 pointer PTE.
module itlb_ptw #(
    parameter int PADDR_WD = 34,
    parameter int VPN_WD   = 20,
    parameter int ASID_WD  = 9,
    parameter int PTE_WD   = 32
) (
    input  logic                clk_i,
    input  logic                rst_i,
    input  logic                flush_i,
    input  logic [31:0]         satp_i,
    input  logic                miss_valid_i,
    output logic                miss_ready_o,
    input  logic [VPN_WD-1:0]   miss_vpn_i,
    input  logic [ASID_WD-1:0]  miss_asid_i,
    output logic                mem_req_valid_o,
    input  logic                mem_req_ready_i,
    output logic [PADDR_WD-1:0] mem_req_addr_o,
    input  logic                mem_rsp_valid_i,
    input  logic [PTE_WD-1:0]   mem_rsp_data_i,
    input  logic                mem_rsp_err_i,
    output logic                refill_valid_o,
    output logic [VPN_WD-1:0]   refill_vpn_o,
    output logic [ASID_WD-1:0]  refill_asid_o,
    output logic [PTE_WD-1:0]   refill_pte_o,
    output logic                refill_mega_o,
    output logic                refill_page_fault_o,
    output logic                refill_access_fault_o
);

    typedef enum logic [2:0] {IDLE, L1_REQ, L1_WAIT, L0_REQ, L0_WAIT, DONE, DRAIN} state_t;

    state_t              state, next_state;
    logic [VPN_WD-1:0]   vpn_q;
    logic [ASID_WD-1:0]  asid_q;
    logic [21:0]         root_ppn_q;
    logic [21:0]         l0_ppn_q;
    logic [PTE_WD-1:0]   pte_q;
    logic                mega_q, pf_q, af_q;
    logic                accept, at_l1, walk_rsp;
    logic                pte_v, pte_r, pte_w, pte_x, pte_a, pte_leaf, rsp_pf, rsp_pointer;
    logic                pde_hit;
    logic [21:0]         pde_ppn;
    logic                unused_satp_asid;

    assign unused_satp_asid = ^satp_i[30:22];
    assign accept = miss_valid_i & miss_ready_o;
    assign at_l1  = (state == L1_WAIT);
    // A response is only meaningful while waiting and not being aborted the same cycle.
    assign walk_rsp = mem_rsp_valid_i & ((state == L1_WAIT) | (state == L0_WAIT)) & ~flush_i;

    assign pte_v    = mem_rsp_data_i[0];
    assign pte_r    = mem_rsp_data_i[1];
    assign pte_w    = mem_rsp_data_i[2];
    assign pte_x    = mem_rsp_data_i[3];
    assign pte_a    = mem_rsp_data_i[6];
    assign pte_leaf = pte_r | pte_x;
    assign rsp_pf   = ~pte_v | (~pte_r & pte_w) | (pte_leaf & (~pte_x | ~pte_a))
                    | (at_l1 & pte_leaf & (|mem_rsp_data_i[19:10]))
                    | (~at_l1 & ~pte_leaf);
    assign rsp_pointer = at_l1 & ~mem_rsp_err_i & ~rsp_pf & ~pte_leaf;

`ifdef ITLB_PTW_PDE_CACHE_EN
    logic                      pde_valid_q;
    logic [ASID_WD+10-1:0]     pde_tag_q;
    logic [21:0]               pde_ppn_q;

    always_ff @(posedge clk_i) begin
        if (rst_i || flush_i) begin
            pde_valid_q <= 1'b0;
            pde_tag_q   <= '0;
            pde_ppn_q   <= '0;
        end else if (walk_rsp && rsp_pointer) begin
            pde_valid_q <= 1'b1;
            pde_tag_q   <= {asid_q, vpn_q[VPN_WD-1:10]};
            pde_ppn_q   <= mem_rsp_data_i[31:10];
        end
    end

    assign pde_hit = pde_valid_q && (pde_tag_q == {miss_asid_i, miss_vpn_i[VPN_WD-1:10]});
    assign pde_ppn = pde_ppn_q;
`else
    assign pde_hit = 1'b0;
    assign pde_ppn = '0;
`endif

    always_ff @(posedge clk_i) begin
        if (rst_i) state <= IDLE;
        else       state <= next_state;
    end

    always_comb begin
        next_state = state;
        case (state)
            IDLE: begin
                if (accept) begin
                    if (!satp_i[31])  next_state = DONE;
                    else if (pde_hit) next_state = L0_REQ;
                    else              next_state = L1_REQ;
                end
            end
            L1_REQ: begin
                if (flush_i)              next_state = IDLE;
                else if (mem_req_ready_i) next_state = L1_WAIT;
            end
            L0_REQ: begin
                if (flush_i)              next_state = IDLE;
                else if (mem_req_ready_i) next_state = L0_WAIT;
            end
            // A response landing in the flush cycle retires the read, so no drain is needed.
            L1_WAIT, L0_WAIT: begin
                if (flush_i)              next_state = mem_rsp_valid_i ? IDLE : DRAIN;
                else if (mem_rsp_valid_i) next_state = rsp_pointer ? L0_REQ : DONE;
            end
            DONE:    next_state = IDLE;
            DRAIN:   if (mem_rsp_valid_i) next_state = IDLE;
            default: next_state = IDLE;
        endcase
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            vpn_q      <= '0;
            asid_q     <= '0;
            root_ppn_q <= '0;
            l0_ppn_q   <= '0;
            pte_q      <= '0;
            mega_q     <= 1'b0;
            pf_q       <= 1'b0;
            af_q       <= 1'b0;
        end else begin
            if (accept) begin
                vpn_q      <= miss_vpn_i;
                asid_q     <= miss_asid_i;
                root_ppn_q <= satp_i[21:0];
                pte_q      <= '0;
                mega_q     <= 1'b0;
                pf_q       <= 1'b0;
                af_q       <= ~satp_i[31];
                if (pde_hit) l0_ppn_q <= pde_ppn;
            end
            if (walk_rsp) begin
                af_q   <= mem_rsp_err_i;
                pf_q   <= ~mem_rsp_err_i & rsp_pf;
                pte_q  <= (mem_rsp_err_i | rsp_pf) ? '0 : mem_rsp_data_i;
                mega_q <= at_l1 & ~mem_rsp_err_i & ~rsp_pf & pte_leaf;
                if (rsp_pointer) l0_ppn_q <= mem_rsp_data_i[31:10];
            end
        end
    end

    always_comb begin
        miss_ready_o          = 1'b0;
        mem_req_valid_o       = 1'b0;
        mem_req_addr_o        = '0;
        refill_valid_o        = 1'b0;
        refill_vpn_o          = '0;
        refill_asid_o         = '0;
        refill_pte_o          = '0;
        refill_mega_o         = 1'b0;
        refill_page_fault_o   = 1'b0;
        refill_access_fault_o = 1'b0;
        if (!rst_i) begin
            miss_ready_o = (state == IDLE) & ~flush_i;
            case (state)
                L1_REQ: begin
                    mem_req_valid_o = ~flush_i;
                    mem_req_addr_o  = PADDR_WD'({root_ppn_q, vpn_q[VPN_WD-1:10], 2'b00});
                end
                L0_REQ: begin
                    mem_req_valid_o = ~flush_i;
                    mem_req_addr_o  = PADDR_WD'({l0_ppn_q, vpn_q[9:0], 2'b00});
                end
                DONE: begin
                    refill_valid_o        = ~flush_i;
                    refill_vpn_o          = vpn_q;
                    refill_asid_o         = asid_q;
                    refill_pte_o          = pte_q;
                    refill_mega_o         = mega_q;
                    refill_page_fault_o   = pf_q;
                    refill_access_fault_o = af_q;
                end
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_itlb_ptw.sv
// Directed self-checking bench for itlb_ptw; expectations follow the Sv32 address and PTE rules.
// Cache-specific expectations switch on ITLB_PTW_PDE_CACHE_EN.
module tb_itlb_ptw;

    localparam logic [8:0]  ASID = 9'h005;
    localparam logic [31:0] SATP = 32'h8000_0100;

    logic        clk = 1'b0;
    logic        rst, flush, miss_valid, miss_ready, mem_req_valid, mem_req_ready;
    logic        mem_rsp_valid, mem_rsp_err, refill_valid, refill_mega, refill_pf, refill_af;
    logic [31:0] satp, mem_rsp_data, refill_pte;
    logic [19:0] miss_vpn, refill_vpn;
    logic [8:0]  miss_asid, refill_asid;
    logic [33:0] mem_req_addr;

    int checks = 0;
    int errors = 0;

    int          obs_lat, obs_reads;
    logic [33:0] obs_addr0, obs_addr1;
    logic [31:0] obs_pte;
    logic [19:0] obs_vpn;
    logic [8:0]  obs_asid;
    logic        obs_mega, obs_pf, obs_af;

    itlb_ptw dut (
        .clk_i(clk), .rst_i(rst), .flush_i(flush), .satp_i(satp),
        .miss_valid_i(miss_valid), .miss_ready_o(miss_ready),
        .miss_vpn_i(miss_vpn), .miss_asid_i(miss_asid),
        .mem_req_valid_o(mem_req_valid), .mem_req_ready_i(mem_req_ready),
        .mem_req_addr_o(mem_req_addr),
        .mem_rsp_valid_i(mem_rsp_valid), .mem_rsp_data_i(mem_rsp_data), .mem_rsp_err_i(mem_rsp_err),
        .refill_valid_o(refill_valid), .refill_vpn_o(refill_vpn), .refill_asid_o(refill_asid),
        .refill_pte_o(refill_pte), .refill_mega_o(refill_mega),
        .refill_page_fault_o(refill_pf), .refill_access_fault_o(refill_af)
    );

    always #5 clk = ~clk;

    task automatic checkOutput(input string tag, input logic [63:0] observed, input logic [63:0] expected);
        checks++;
        assert (observed === expected) else begin
            errors++;
            $error("[TB] FAIL %s: observed %0h expected %0h", tag, observed, expected);
        end
    endtask

    // One walk with an always-ready memory answering one cycle after each accepted read.
    task automatic applyStimulus(input logic pre_flush, input logic [19:0] vpn, input logic [31:0] sp,
                                 input logic [31:0] d0, input logic e0,
                                 input logic [31:0] d1, input logic e1);
        logic pending;
        int   n;
        pending = 1'b0;
        n = 0;
        obs_lat = 0; obs_addr0 = '0; obs_addr1 = '0; obs_pte = '0;
        obs_vpn = '0; obs_asid = '0; obs_mega = 1'b0; obs_pf = 1'b0; obs_af = 1'b0;
        @(negedge clk);
        if (pre_flush) begin
            flush = 1'b1;
            @(negedge clk);
            flush = 1'b0;
        end
        satp = sp; miss_vpn = vpn; miss_asid = ASID; miss_valid = 1'b1;
        @(negedge clk);
        miss_valid = 1'b0;
        satp = 32'h0;
        for (int cyc = 1; cyc <= 20; cyc++) begin
            if (pending) begin
                mem_rsp_valid = 1'b1;
                mem_rsp_data  = (n == 1) ? d0 : d1;
                mem_rsp_err   = (n == 1) ? e0 : e1;
                pending = 1'b0;
            end else begin
                mem_rsp_valid = 1'b0; mem_rsp_data = '0; mem_rsp_err = 1'b0;
            end
            if (refill_valid) begin
                obs_lat = cyc; obs_pte = refill_pte; obs_vpn = refill_vpn; obs_asid = refill_asid;
                obs_mega = refill_mega; obs_pf = refill_pf; obs_af = refill_af;
                break;
            end
            if (mem_req_valid) begin
                if (n == 0) obs_addr0 = mem_req_addr;
                else        obs_addr1 = mem_req_addr;
                n++;
                pending = 1'b1;
            end
            @(negedge clk);
        end
        mem_rsp_valid = 1'b0; mem_rsp_data = '0; mem_rsp_err = 1'b0;
        obs_reads = n;
        @(negedge clk);
        checkOutput("single_pulse", refill_valid, 1'b0);
        checkOutput("ready_after_walk", miss_ready, 1'b1);
    endtask

    initial begin
        rst = 1'b1; flush = 1'b0; satp = '0; miss_valid = 1'b0; miss_vpn = '0; miss_asid = '0;
        mem_req_ready = 1'b1; mem_rsp_valid = 1'b0; mem_rsp_data = '0; mem_rsp_err = 1'b0;

        @(negedge clk);
        @(negedge clk);
        checkOutput("rst_ready", miss_ready, 1'b0);
        checkOutput("rst_req", mem_req_valid, 1'b0);
        checkOutput("rst_refill", refill_valid, 1'b0);
        rst = 1'b0;
        @(negedge clk);
        checkOutput("ready_after_rst", miss_ready, 1'b1);

        // 4 KiB walk through a pointer PTE with PPN 0x20.
        applyStimulus(1'b1, 20'h12345, SATP, 32'h0000_8001, 1'b0, 32'h1234_504B, 1'b0);
        checkOutput("page_reads", obs_reads, 2);
        checkOutput("page_l1_addr", obs_addr0, 34'h0_0010_0120);
        checkOutput("page_l0_addr", obs_addr1, 34'h0_0002_0D14);
        checkOutput("page_latency", obs_lat, 5);
        checkOutput("page_pte", obs_pte, 32'h1234_504B);
        checkOutput("page_vpn", obs_vpn, 20'h12345);
        checkOutput("page_asid", obs_asid, ASID);
        checkOutput("page_flags", {obs_mega, obs_pf, obs_af}, 3'b000);

        applyStimulus(1'b1, 20'h12345, SATP, 32'h4000_004B, 1'b0, 32'h0, 1'b0);
        checkOutput("mega_reads", obs_reads, 1);
        checkOutput("mega_latency", obs_lat, 3);
        checkOutput("mega_pte", obs_pte, 32'h4000_004B);
        checkOutput("mega_flags", {obs_mega, obs_pf, obs_af}, 3'b100);

        applyStimulus(1'b1, 20'h12345, SATP, 32'h4000_044B, 1'b0, 32'h0, 1'b0);
        checkOutput("misaligned_reads", obs_reads, 1);
        checkOutput("misaligned_pte", obs_pte, 32'h0);
        checkOutput("misaligned_flags", {obs_mega, obs_pf, obs_af}, 3'b010);

        applyStimulus(1'b1, 20'h12345, SATP, 32'h0000_8001, 1'b0, 32'h1234_5043, 1'b0);
        checkOutput("nox_latency", obs_lat, 5);
        checkOutput("nox_pte", obs_pte, 32'h0);
        checkOutput("nox_flags", {obs_mega, obs_pf, obs_af}, 3'b010);

        applyStimulus(1'b1, 20'h12345, SATP, 32'h4000_004B, 1'b1, 32'h0, 1'b0);
        checkOutput("err_latency", obs_lat, 3);
        checkOutput("err_pte", obs_pte, 32'h0);
        checkOutput("err_flags", {obs_mega, obs_pf, obs_af}, 3'b001);

        applyStimulus(1'b1, 20'h12345, SATP, 32'h0000_8005, 1'b0, 32'h0, 1'b0);
        checkOutput("wnr_flags", {obs_mega, obs_pf, obs_af}, 3'b010);

        applyStimulus(1'b1, 20'h12345, SATP, 32'h0000_8001, 1'b0, 32'h0000_8001, 1'b0);
        checkOutput("l0_pointer_latency", obs_lat, 5);
        checkOutput("l0_pointer_flags", {obs_mega, obs_pf, obs_af}, 3'b010);

        applyStimulus(1'b1, 20'h12345, 32'h0000_0100, 32'h0, 1'b0, 32'h0, 1'b0);
        checkOutput("bare_reads", obs_reads, 0);
        checkOutput("bare_latency", obs_lat, 1);
        checkOutput("bare_flags", {obs_mega, obs_pf, obs_af}, 3'b001);

        // Flush while the level-1 read is outstanding; the response trails by four cycles.
        @(negedge clk);
        flush = 1'b1;
        @(negedge clk);
        flush = 1'b0;
        satp = SATP; miss_vpn = 20'h12345; miss_asid = ASID; miss_valid = 1'b1;
        @(negedge clk);
        miss_valid = 1'b0;
        checkOutput("flush_l1_req", mem_req_valid, 1'b1);
        @(negedge clk);
        flush = 1'b1;
        checkOutput("flush_ready_low", miss_ready, 1'b0);
        for (int cyc = 3; cyc <= 6; cyc++) begin
            @(negedge clk);
            flush = 1'b0;
            checkOutput("drain_no_refill", refill_valid, 1'b0);
            checkOutput("drain_not_ready", miss_ready, 1'b0);
        end
        mem_rsp_valid = 1'b1; mem_rsp_data = 32'h4000_004B;
        @(negedge clk);
        mem_rsp_valid = 1'b0; mem_rsp_data = '0;
        checkOutput("drain_ready", miss_ready, 1'b1);
        checkOutput("drain_discard", refill_valid, 1'b0);
        @(negedge clk);
        checkOutput("drain_quiet", refill_valid, 1'b0);

        applyStimulus(1'b0, 20'h12345, SATP, 32'h0000_8001, 1'b0, 32'h1234_504B, 1'b0);
        checkOutput("post_flush_reads", obs_reads, 2);
        checkOutput("post_flush_latency", obs_lat, 5);
        checkOutput("post_flush_pte", obs_pte, 32'h1234_504B);

        // Back-to-back walks sharing VPN[1] and ASID.
        applyStimulus(1'b1, 20'h12345, SATP, 32'h0000_8001, 1'b0, 32'h1234_504B, 1'b0);
`ifdef ITLB_PTW_PDE_CACHE_EN
        applyStimulus(1'b0, 20'h12346, SATP, 32'h1234_604B, 1'b0, 32'h0, 1'b0);
        checkOutput("pde_hit_reads", obs_reads, 1);
        checkOutput("pde_hit_addr", obs_addr0, 34'h0_0002_0D18);
        checkOutput("pde_hit_latency", obs_lat, 3);
`else
        applyStimulus(1'b0, 20'h12346, SATP, 32'h0000_8001, 1'b0, 32'h1234_604B, 1'b0);
        checkOutput("second_reads", obs_reads, 2);
        checkOutput("second_l0_addr", obs_addr1, 34'h0_0002_0D18);
        checkOutput("second_latency", obs_lat, 5);
`endif
        checkOutput("second_pte", obs_pte, 32'h1234_604B);
        checkOutput("second_vpn", obs_vpn, 20'h12346);
        applyStimulus(1'b1, 20'h12346, SATP, 32'h0000_8001, 1'b0, 32'h1234_604B, 1'b0);
        checkOutput("third_reads", obs_reads, 2);
        checkOutput("third_l1_addr", obs_addr0, 34'h0_0010_0120);

        // Reset in the middle of a walk; the memory side drops its response.
        @(negedge clk);
        satp = SATP; miss_vpn = 20'h12345; miss_asid = ASID; miss_valid = 1'b1;
        @(negedge clk);
        miss_valid = 1'b0;
        @(negedge clk);
        rst = 1'b1;
        #1;
        checkOutput("midrst_req", mem_req_valid, 1'b0);
        checkOutput("midrst_ready", miss_ready, 1'b0);
        @(negedge clk);
        rst = 1'b0;
        @(negedge clk);
        checkOutput("midrst_idle", miss_ready, 1'b1);
        checkOutput("midrst_no_refill", refill_valid, 1'b0);
        applyStimulus(1'b0, 20'h12345, SATP, 32'h4000_004B, 1'b0, 32'h0, 1'b0);
        checkOutput("midrst_next_latency", obs_lat, 3);
        checkOutput("midrst_next_pte", obs_pte, 32'h4000_004B);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
